cmd_responder: RTL and testbench

Command-processing responder behind `UART_wrapper`, the serial-side end of the `CommMaster` link. Consumes each 16-bit command the wrapper assembles, executes it against a local 16 x 8 register bank, and returns exactly one 8-bit response byte through the wrapper's send path. Completes the command/response loop: `CommMaster` initiates, `cmd_responder` answers.

---
 rtl/cmd_responder_pkg.sv | 33 +++
 rtl/cmd_responder_if.sv | 28 ++
 rtl/cmd_responder_regfile.sv | 41 ++++
 rtl/cmd_responder.sv | 101 ++++++++++
 tb/tb_cmd_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_responder_pkg.sv
// cmd_responder_pkg: shared types and command-field layout for the
// command responder slice.
//   opcode_t : command opcodes carried in cmd[15:12]
//   state_t  : responder FSM states
//   *_MSB/*_LSB : bit ranges of the opcode, address and data fields
package cmd_responder_pkg;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_PING  = 4'h3,
    OP_INC   = 4'h4
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SEND,
    S_WAIT_SENT
  } state_t;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned ADDR_W   = 4;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned ADDR_MSB = 11;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

endpackage

// File: rtl/cmd_responder_if.sv
// cmd_responder_if: command/response handshake between UART_wrapper and
// cmd_responder.
//   cmd_rdy/cmd     : complete command held by the wrapper
//   clr_cmd_rdy     : pulse that clears cmd_rdy in the wrapper
//   send_resp/resp  : pulse starting transmission of the response byte
//   resp_sent       : pulse when the response byte has shifted out
// master = wrapper side, slave = responder side.
interface cmd_responder_if;
  import cmd_responder_pkg::*;

  logic              cmd_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [REG_W-1:0]  resp;
  logic              resp_sent;

  modport master (
    output cmd_rdy, cmd, resp_sent,
    input  clr_cmd_rdy, send_resp, resp
  );

  modport slave (
    input  cmd_rdy, cmd, resp_sent,
    output clr_cmd_rdy, send_resp, resp
  );

endinterface

// File: rtl/cmd_responder_regfile.sv
// cmd_regfile: 16 x 8 register bank.
//   clk, rst        : clock, async active-high reset (clears all entries)
//   we, inc         : write enable; inc selects mem+1 instead of wdata
//   waddr, wdata    : synchronous write port
//   raddr_a/rdata_a : asynchronous read port (responder decode)
//   raddr_b/rdata_b : asynchronous read port (system side)
module cmd_regfile
  import cmd_responder_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              inc,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [REG_W-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [REG_W-1:0]  rdata_b
);

  logic [REG_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      // Increment is modulo 2^8: 8'hFF wraps to 8'h00.
      mem[waddr] <= inc ? mem[waddr] + 8'd1 : wdata;
    end
  end

  // Reads see the pre-write value in the write cycle.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/cmd_responder.sv
// cmd_responder: executes 16-bit commands from UART_wrapper against a local
// register bank and returns one response byte per command.
//   clk, rst : clock, async active-high reset
//   bus      : handshake with UART_wrapper (slave side)
//   rd_addr  : system-side read address into the register bank
//   rd_data  : register contents at rd_addr (combinational)
//   busy     : high whenever the FSM is not idle
module cmd_responder
  import cmd_responder_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [7:0]  ACK       = 8'hA5,
  parameter logic [7:0]  NACK      = 8'hEE,
  parameter logic [7:0]  PING_RESP = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  cmd_responder_if.slave    bus,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [REG_W-1:0]  rd_data,
  output logic              busy
);

  state_t           state, state_nxt;
  logic [CMD_W-1:0] cmd_q;
  logic [REG_W-1:0] resp_q, resp_d;
  logic [REG_W-1:0] dec_data;
  logic             clr_q, clr_d;
  logic             send_q, send_d;
  logic             wr_en, wr_inc;
  opcode_t          op;

  assign op = opcode_t'(cmd_q[OP_MSB:OP_LSB]);

  // State register; the handshake pulses are registered so clr_cmd_rdy
  // occupies the DECODE cycle and send_resp the first WAIT_SENT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      clr_q  <= 1'b0;
      send_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      clr_q  <= clr_d;
      send_q <= send_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (bus.cmd_rdy) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = S_SEND;
      S_SEND:      state_nxt = S_WAIT_SENT;
      S_WAIT_SENT: if (bus.resp_sent) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clr_d  = (state == S_IDLE) && bus.cmd_rdy;
    send_d = (state == S_SEND);
    busy   = (state != S_IDLE);
    wr_en  = (state == S_DECODE) && ((op == OP_WRITE) || (op == OP_INC));
    wr_inc = (op == OP_INC);
    case (op)
      OP_WRITE, OP_INC: resp_d = ACK;
      OP_READ:          resp_d = dec_data;
      OP_PING:          resp_d = PING_RESP;
      default:          resp_d = NACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= '0;
      resp_q <= '0;
    end else begin
      if ((state == S_IDLE) && bus.cmd_rdy) cmd_q <= bus.cmd;
      if (state == S_DECODE) resp_q <= resp_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_q;
  assign bus.send_resp   = send_q;
  assign bus.resp        = resp_q;

  cmd_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .inc     (wr_inc),
    .waddr   (cmd_q[ADDR_MSB:ADDR_LSB]),
    .wdata   (cmd_q[DATA_MSB:DATA_LSB]),
    .raddr_a (cmd_q[ADDR_MSB:ADDR_LSB]),
    .rdata_a (dec_data),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: directed bench for cmd_responder. Stimulus pushes the
// expected response byte into a queue; a monitor pops and compares on every
// send_resp. A small UART model answers each send_resp with resp_sent.
module tb_cmd_responder;
  import cmd_responder_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       uart_sent, stray_sent, uart_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_exp;
  logic [7:0] m [16];

  cmd_responder_if bus ();
  assign bus.resp_sent = uart_sent | stray_sent;

  cmd_responder #(
    .NUM_REGS  (16),
    .ACK       (8'hA5),
    .NACK      (8'hEE),
    .PING_RESP (8'h5A)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every send_resp must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.send_resp) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_send_resp actual=%h required=none", bus.resp);
      end else begin
        last_exp = exp_q.pop_front();
        if (bus.resp !== last_exp) begin
          errors++;
          $display("FAIL resp actual=%h required=%h", bus.resp, last_exp);
        end
      end
    end
  end

  // UART model: response shifts out over 3 cycles; resp must hold throughout.
  initial begin
    uart_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_resp && uart_en) begin
        repeat (3) begin
          @(negedge clk);
          chk8("resp_hold", bus.resp, last_exp);
        end
        uart_sent = 1'b1;
        @(negedge clk);
        uart_sent = 1'b0;
        chk8("resp_hold_sent", bus.resp, last_exp);
      end
    end
  end

  task automatic chk_all(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk8($sformatf("%s_reg%0d", name, i), rd_data, m[i]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("idle_timeout", n < 100, 1'b1);
  endtask

  // Issue one command from idle; optionally watch the same-cycle
  // read-during-write behaviour on rd_addr=a.
  task automatic issue(input logic [15:0] c, input logic [7:0] e,
                       input bit chk_rd, input logic [3:0] a,
                       input logic [7:0] oldv, input logic [7:0] newv);
    int  n = 0;
    bit  seen = 0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cmd = c;
    bus.cmd_rdy = 1'b1;
    rd_addr = a;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.clr_cmd_rdy;
    end
    chkn($sformatf("clr_latency_%h", c), n, 1);
    bus.cmd_rdy = 1'b0;
    if (chk_rd) chk8($sformatf("rd_old_%h", c), rd_data, oldv);
    @(negedge clk);
    chk1($sformatf("send_gap_%h", c), bus.send_resp, 1'b0);
    chk1($sformatf("clr_pulse_%h", c), bus.clr_cmd_rdy, 1'b0);
    if (chk_rd) chk8($sformatf("rd_new_%h", c), rd_data, newv);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int  n;
    bit  early;
    rst = 1'b1;
    bus.cmd_rdy = 1'b0;
    bus.cmd = '0;
    rd_addr = '0;
    stray_sent = 1'b0;
    uart_en = 1'b1;
    last_exp = '0;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_clr", bus.clr_cmd_rdy, 1'b0);
    chk1("rst_send", bus.send_resp, 1'b0);
    chk8("rst_resp", bus.resp, 8'h00);
    chk_all("rst");
    rst = 1'b0;

    // PING
    issue(16'h3000, 8'h5A, 0, 4'h0, 8'h00, 8'h00);
    wait_idle();
    chk_all("ping");

    // WRITE then READ, with read-during-write on rd_addr=3
    issue(16'h137C, 8'hA5, 1, 4'h3, 8'h00, 8'h7C);
    m[3] = 8'h7C;
    wait_idle();
    issue(16'h2300, 8'h7C, 0, 4'h3, 8'h00, 8'h00);
    wait_idle();

    // Increment wrap
    issue(16'h19FF, 8'hA5, 1, 4'h9, 8'h00, 8'hFF);
    wait_idle();
    issue(16'h4900, 8'hA5, 1, 4'h9, 8'hFF, 8'h00);
    m[9] = 8'h00;
    wait_idle();

    // Non-wrapping increment
    issue(16'h4300, 8'hA5, 1, 4'h3, 8'h7C, 8'h7D);
    m[3] = 8'h7D;
    wait_idle();

    // Unknown opcodes leave the bank untouched
    issue(16'hF123, 8'hEE, 0, 4'h1, 8'h00, 8'h00);
    wait_idle();
    issue(16'h0A55, 8'hEE, 0, 4'hA, 8'h00, 8'h00);
    wait_idle();
    chk_all("unknown");

    // Back-to-back: second command raised during WAIT_SENT
    issue(16'h3000, 8'h5A, 0, 4'h0, 8'h00, 8'h00);
    n = 0;
    while (!bus.send_resp && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1("b2b_send_seen", bus.send_resp, 1'b1);
    exp_q.push_back(8'h7D);
    bus.cmd = 16'h2300;
    bus.cmd_rdy = 1'b1;
    early = 0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      early = early | bus.clr_cmd_rdy;
    end while (!bus.resp_sent && n < 20);
    chk1("b2b_resp_sent_seen", bus.resp_sent, 1'b1);
    chk1("b2b_no_early_clr", early, 1'b0);
    @(negedge clk);
    chk1("b2b_clr_m1", bus.clr_cmd_rdy, 1'b0);
    @(negedge clk);
    chk1("b2b_clr_m2", bus.clr_cmd_rdy, 1'b1);
    bus.cmd_rdy = 1'b0;
    wait_idle();

    // Reset in WAIT_SENT
    uart_en = 1'b0;
    issue(16'h1555, 8'hA5, 1, 4'h5, 8'h00, 8'h55);
    @(negedge clk);
    chk1("wr_send", bus.send_resp, 1'b1);
    @(negedge clk);
    chk1("wr_busy_wait", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk8("mid_rst_resp", bus.resp, 8'h00);
    chk1("mid_rst_send", bus.send_resp, 1'b0);
    chk1("mid_rst_clr", bus.clr_cmd_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    chk_all("mid_rst");
    stray_sent = 1'b1;
    @(negedge clk);
    stray_sent = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk1("stray_clr", bus.clr_cmd_rdy, 1'b0);
      chk1("stray_send", bus.send_resp, 1'b0);
      chk1("stray_busy", busy, 1'b0);
    end
    uart_en = 1'b1;

    // Recovery after reset
    issue(16'h3000, 8'h5A, 0, 4'h0, 8'h00, 8'h00);
    wait_idle();
    repeat (3) @(negedge clk);
    chkn("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
